timer_sched: RTL
================

// Module: timer_sched
// PURPOSE
//  Sequencing controller for the four GBA hardware timer counters. It decodes each TMxCNT_H
//  control word and produces, per timer:
//   - a count-enable strobe (prescaled, or cascaded from the previous timer's overflow);
//   - a reload strobe when the timer starts;
//   - a latched overflow IRQ request, held until acknowledged.
//  Sits between the MMIO register file / IRQ controller and the timer counter datapath;
//  the counters only increment when told.
// PARAMETERS
//  NUM_TIMERS   4    number of timer channels scheduled (cascade chain order 0..N-1)
//  PRESCALE_W   10   per-timer prescaler width; must cover divide-by-1024
// PORTS
//  clock_16     in   1         system clock (16.78 MHz)
//  reset        in   1         asynchronous, active-low reset
//  TM0CNT_H     in   16        timer0 control: [1:0] prescale sel, [2] cascade, [6] IRQ en, [7] enable
//  TM1CNT_H     in   16        timer1 control, same layout
//  TM2CNT_H     in   16        timer2 control, same layout
//  TM3CNT_H     in   16        timer3 control, same layout
//  ovf          in   NUM_TIMERS  one-cycle overflow pulse from each counter
//  irq_ack      in   NUM_TIMERS  one-cycle acknowledge per pending IRQ, from IRQ controller
//  tick         out  NUM_TIMERS  count-enable to each counter, one cycle per increment
//  reload       out  NUM_TIMERS  load-reload-value strobe to each counter
//  irq_pend     out  NUM_TIMERS  latched IRQ request level per timer
//  running      out  NUM_TIMERS  timer is in RUN state (status/debug)
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, prescalers 0, all channels IDLE, en_q=0.
//  Per-channel FSM, states IDLE -> START -> RUN:
//   - IDLE -> START: when enable bit [7]=1 and en_q=0 (rising edge, cycle N).
//   - START (cycle N+1): reload=1 for exactly one cycle; prescaler cleared to 0.
//   - START -> RUN: unconditional at N+2.
//   - RUN -> IDLE: next edge after [7]=0.
//   - Any state -> IDLE: whenever [7]=0. tick is also gated combinationally by [7], so no
//     tick occurs in the cycle the bit reads 0.
//   - en_q is a registered copy of [7]. Re-enable from IDLE always repeats START (reload).
//  Prescaler (RUN only, cascade=0): increments every cycle, wraps at 2^PRESCALE_W.
//   sel=0: tick every RUN cycle.
//   sel=1: tick when pre[5:0]==63 (every 64 cycles; first tick is the 64th RUN cycle).
//   sel=2: tick when pre[7:0]==255.
//   sel=3: tick when pre[9:0]==1023.
//   - A sel change while in RUN takes effect the next cycle; the prescaler is not cleared.
//  Cascade ([2]=1, channel i>=1, RUN): tick[i] = ovf[i-1], combinational, same cycle;
//   the prescaler is ignored. Channel 0 ignores [2] and always uses its prescaler.
//  IRQ:
//   - irq_pend[i] sets on the edge after ovf[i]=1 when [6]=1 and the channel is in RUN.
//   - irq_pend[i] clears on the edge after irq_ack[i]=1.
//   - ovf and ack in the same cycle: set wins, pend stays 1.
//   - Clearing [6] does not clear an already-pending request.
//  No reload is issued on overflow; the counter datapath reloads itself on overflow.
//  Channels are independent apart from the cascade path.
//  Async reset mid-count: everything returns to the reset state immediately. After release,
//   a channel whose [7] is already 1 sees a rising edge (en_q=0) and runs START normally.
// TESTING
//  1. TM0 [7]=1, sel=0 at cycle N -> reload[0]=1 at N+1 only; tick[0]=1 every cycle from N+2.
//  2. TM1 sel=1 enabled -> first tick[1] on the 64th RUN cycle, then ticks spaced exactly
//     64 cycles. sel=3 -> 1024-cycle spacing.
//  3. TM2 cascade=1 in RUN, pulse ovf[1] three times -> exactly three tick[2] pulses, each in
//     the same cycle as its ovf[1]; no other ticks.
//  4. TM3 [6]=1: ovf[3] -> irq_pend[3]=1 next cycle. irq_ack[3] alone -> clears next cycle.
//     ovf[3] and irq_ack[3] in the same cycle -> irq_pend[3] stays 1.
//  5. Running sel=0 timer, drop [7] -> tick=0 that same cycle; running=0 next cycle.
//     Re-raise [7] -> new reload pulse, then ticks.
//  6. Assert reset low mid-RUN with irq_pend=1 -> all outputs 0 without a clock edge.
//     Release with [7]=1 -> START (reload) on the first edge after release.

Source files
------------

// File: rtl/timer_sched.sv
// Four-channel GBA timer sequencer: start/reload, prescale or cascade
// tick generation, and latched overflow IRQ requests.
module timer_sched #(
  parameter int NUM_TIMERS = 4,
  parameter int PRESCALE_W = 10
) (
  input  logic                  clock_16,
  input  logic                  reset,
  input  logic [15:0]           TM0CNT_H,
  input  logic [15:0]           TM1CNT_H,
  input  logic [15:0]           TM2CNT_H,
  input  logic [15:0]           TM3CNT_H,
  input  logic [NUM_TIMERS-1:0] ovf,
  input  logic [NUM_TIMERS-1:0] irq_ack,
  output logic [NUM_TIMERS-1:0] tick,
  output logic [NUM_TIMERS-1:0] reload,
  output logic [NUM_TIMERS-1:0] irq_pend,
  output logic [NUM_TIMERS-1:0] running
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  logic [15:0] cnt [4];

  assign cnt[0] = TM0CNT_H;
  assign cnt[1] = TM1CNT_H;
  assign cnt[2] = TM2CNT_H;
  assign cnt[3] = TM3CNT_H;

  // timer 0 has no predecessor, so its cascade bit is meaningless
  logic unused_ctl;
  assign unused_ctl = ^{TM0CNT_H[15:8], TM0CNT_H[5:2],
                        TM1CNT_H[15:8], TM1CNT_H[5:3],
                        TM2CNT_H[15:8], TM2CNT_H[5:3],
                        TM3CNT_H[15:8], TM3CNT_H[5:3]};

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
    state_t                state_q;
    state_t                state_d;
    logic                  en_q;
    logic [PRESCALE_W-1:0] pre_q;
    logic                  en;
    logic                  irq_en;
    logic                  cas;
    logic                  cas_tick;
    logic                  pre_hit;
    logic                  is_run;

    assign en     = cnt[i][7];
    assign irq_en = cnt[i][6];
    assign is_run = (state_q == RUN);

    if (i == 0) begin : g_nocas
      assign cas      = 1'b0;
      assign cas_tick = 1'b0;
    end else begin : g_cas
      assign cas      = cnt[i][2];
      assign cas_tick = ovf[i-1];
    end

    // prescaler tap select: all-ones on the low 0/6/8/10 bits
    always_comb begin
      pre_hit = 1'b0;
      unique case (cnt[i][1:0])
        2'd0:    pre_hit = 1'b1;
        2'd1:    pre_hit = &pre_q[5:0];
        2'd2:    pre_hit = &pre_q[7:0];
        default: pre_hit = &pre_q[9:0];
      endcase
    end

    // next state: enable low always wins and forces IDLE
    always_comb begin
      state_d = state_q;
      if (!en) begin
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE:    if (!en_q) state_d = START;
          START:   state_d = RUN;
          RUN:     state_d = RUN;
          default: state_d = IDLE;
        endcase
      end
    end

    // state register and enable edge history
    always_ff @(posedge clock_16 or negedge reset) begin
      if (!reset) begin
        state_q <= IDLE;
        en_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        en_q    <= en;
      end
    end

    // prescaler: cleared on start, free-running while in RUN
    always_ff @(posedge clock_16 or negedge reset) begin
      if (!reset) begin
        pre_q <= '0;
      end else if (state_q == START) begin
        pre_q <= '0;
      end else if (is_run && !cas) begin
        pre_q <= pre_q + PRESCALE_W'(1);
      end
    end

    // overflow IRQ latch; a new overflow beats a same-cycle ack
    always_ff @(posedge clock_16 or negedge reset) begin
      if (!reset) begin
        irq_pend[i] <= 1'b0;
      end else if (ovf[i] && irq_en && is_run) begin
        irq_pend[i] <= 1'b1;
      end else if (irq_ack[i]) begin
        irq_pend[i] <= 1'b0;
      end
    end

    assign tick[i]    = en && is_run && (cas ? cas_tick : pre_hit);
    assign reload[i]  = (state_q == START);
    assign running[i] = is_run;
  end

endmodule
